datamem_arbiter: RTL and testbench

- Two-port arbiter and access sequencer in front of the shared data memory (1024-byte, little-endian, synchronous write, combinational read).
- Port 0 serves the pipeline MEM stage; port 1 serves the debug/DMA loader.
- Grants one transaction at a time and checks alignment, size and bounds before the memory is touched.
- Registers each response and returns it to the granted requester with fixed latency.

---
 rtl/datamem_arbiter_if.sv | 42 ++++
 rtl/datamem_arbiter.sv | 153 +++++++++++++++
 tb/tb_datamem_arbiter.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/datamem_arbiter_if.sv
// Request/response and data-memory signal bundle for datamem_arbiter.
// The slave modport is the arbiter's view; the master modport is the view of
// whatever surrounds it (requesters plus the data memory).
interface datamem_arbiter_if;
  // Requester side, bit/suffix i belongs to port i
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req_write;
  logic [63:0] req_addr0;
  logic [63:0] req_addr1;
  logic [63:0] req_wdata0;
  logic [63:0] req_wdata1;
  logic [3:0]  req_size0;
  logic [3:0]  req_size1;

  // Completion returned to the granted port
  logic [1:0]  resp_valid;
  logic        resp_err;
  logic [63:0] resp_rdata;

  // Data memory side
  logic [63:0] mem_address;
  logic        mem_write_enable;
  logic        mem_read_enable;
  logic [63:0] mem_write_data;
  logic [3:0]  mem_xfer_size;
  logic [63:0] mem_read_data;

  modport slave (
    input  req_valid, req_write, req_addr0, req_addr1, req_wdata0, req_wdata1,
           req_size0, req_size1, mem_read_data,
    output req_ready, resp_valid, resp_err, resp_rdata,
           mem_address, mem_write_enable, mem_read_enable, mem_write_data, mem_xfer_size
  );

  modport master (
    output req_valid, req_write, req_addr0, req_addr1, req_wdata0, req_wdata1,
           req_size0, req_size1, mem_read_data,
    input  req_ready, resp_valid, resp_err, resp_rdata,
           mem_address, mem_write_enable, mem_read_enable, mem_write_data, mem_xfer_size
  );
endinterface

// File: rtl/datamem_arbiter.sv
// Two-port arbiter and access sequencer for the shared data memory.
// One transaction at a time: IDLE grants and checks, ACCESS drives the memory for
// one cycle, RESP returns a one-cycle completion to the granted port.
module datamem_arbiter #(
  parameter int unsigned MEM_SIZE   = 1024,
  parameter int unsigned FIXED_PRIO = 0
) (
  input logic              clk,
  input logic              reset_n,
  datamem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e      state_q;
  logic        last_grant_q;
  logic        grant_q;
  logic        write_q;
  logic        err_q;
  logic [1:0]  resp_valid_q;
  logic        resp_err_q;
  logic [63:0] rdata_q;
  logic [63:0] mem_address_q;
  logic [63:0] mem_write_data_q;
  logic [3:0]  mem_xfer_size_q;
  logic        mem_write_enable_q;
  logic        mem_read_enable_q;

  logic        any_valid;
  logic        win;
  logic        sel_write;
  logic [63:0] sel_addr;
  logic [63:0] sel_wdata;
  logic [3:0]  sel_size;
  logic        size_ok;
  logic        misaligned;
  logic        out_of_bounds;
  logic        sel_err;
  logic [64:0] end_addr;
  logic [1:0]  req_ready;

  // Pick the winning port among the current valid requests
  always_comb begin
    any_valid = |bus.req_valid;
    win       = 1'b0;
    case (bus.req_valid)
      2'b01:   win = 1'b0;
      2'b10:   win = 1'b1;
      // Tie: either fixed priority to port 0 or alternate away from the last grant
      2'b11:   win = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant_q;
      default: win = 1'b0;
    endcase
  end

  // Mux the winner's request and decide whether it must be rejected
  always_comb begin
    sel_write = bus.req_write[win];
    sel_addr  = win ? bus.req_addr1  : bus.req_addr0;
    sel_wdata = win ? bus.req_wdata1 : bus.req_wdata0;
    sel_size  = win ? bus.req_size1  : bus.req_size0;

    case (sel_size)
      4'd1, 4'd2, 4'd4, 4'd8: size_ok = 1'b1;
      default:                size_ok = 1'b0;
    endcase

    misaligned    = (sel_addr & ({60'd0, sel_size} - 64'd1)) != 64'd0;
    // 65-bit sum so an address near 2^64 cannot wrap into range
    end_addr      = {1'b0, sel_addr} + {61'd0, sel_size};
    out_of_bounds = end_addr > 65'(MEM_SIZE);
    sel_err       = !size_ok || misaligned || out_of_bounds;
  end

  // Accept goes only to the winner; with nothing pending both ports read as ready
  always_comb begin
    req_ready = 2'b00;
    if (state_q == StIdle) begin
      if (!any_valid) begin
        req_ready = 2'b11;
      end else begin
        req_ready = win ? 2'b10 : 2'b01;
      end
    end
  end

  // Sequencer FSM with registered memory and response outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q            <= StIdle;
      last_grant_q       <= 1'b1;
      grant_q            <= 1'b0;
      write_q            <= 1'b0;
      err_q              <= 1'b0;
      resp_valid_q       <= 2'b00;
      resp_err_q         <= 1'b0;
      rdata_q            <= 64'd0;
      mem_address_q      <= 64'd0;
      mem_write_data_q   <= 64'd0;
      mem_xfer_size_q    <= 4'd8;
      mem_write_enable_q <= 1'b0;
      mem_read_enable_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (any_valid) begin
            grant_q            <= win;
            last_grant_q       <= win;
            write_q            <= sel_write;
            err_q              <= sel_err;
            mem_address_q      <= sel_addr;
            mem_write_data_q   <= sel_wdata;
            mem_xfer_size_q    <= sel_size;
            // A rejected request never touches the memory
            mem_write_enable_q <= sel_write & ~sel_err;
            mem_read_enable_q  <= ~sel_write & ~sel_err;
            state_q            <= StAccess;
          end
        end
        StAccess: begin
          rdata_q            <= (!write_q && !err_q) ? bus.mem_read_data : 64'd0;
          resp_valid_q       <= grant_q ? 2'b10 : 2'b01;
          resp_err_q         <= err_q;
          mem_address_q      <= 64'd0;
          mem_write_data_q   <= 64'd0;
          mem_xfer_size_q    <= 4'd8;
          mem_write_enable_q <= 1'b0;
          mem_read_enable_q  <= 1'b0;
          state_q            <= StResp;
        end
        StResp: begin
          resp_valid_q <= 2'b00;
          resp_err_q   <= 1'b0;
          rdata_q      <= 64'd0;
          state_q      <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.req_ready        = req_ready;
  assign bus.resp_valid       = resp_valid_q;
  assign bus.resp_err         = resp_err_q;
  assign bus.resp_rdata       = rdata_q;
  assign bus.mem_address      = mem_address_q;
  assign bus.mem_write_enable = mem_write_enable_q;
  assign bus.mem_read_enable  = mem_read_enable_q;
  assign bus.mem_write_data   = mem_write_data_q;
  assign bus.mem_xfer_size    = mem_xfer_size_q;

endmodule

// File: tb/tb_datamem_arbiter.sv
// Bench for datamem_arbiter: a round-robin instance backed by a byte-array data
// memory, plus a fixed-priority instance used only for grant ordering.
module tb_datamem_arbiter;
  localparam int unsigned MemSize = 1024;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic mem_clear = 1'b1;
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  logic [3:0] sz_tab [4];

  always #5 clk = ~clk;

  datamem_arbiter_if rr_if ();
  datamem_arbiter_if fp_if ();

  datamem_arbiter #(.MEM_SIZE(MemSize), .FIXED_PRIO(0)) dut_rr (
    .clk(clk), .reset_n(reset_n), .bus(rr_if)
  );
  datamem_arbiter #(.MEM_SIZE(MemSize), .FIXED_PRIO(1)) dut_fp (
    .clk(clk), .reset_n(reset_n), .bus(fp_if)
  );

  // Data memory: synchronous write, combinational little-endian read
  logic [7:0]  mem [MemSize];
  logic [63:0] mem_rd;

  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < int'(MemSize); i++) mem[i] <= 8'h00;
    end else if (rr_if.mem_write_enable) begin
      for (int i = 0; i < 8; i++) begin
        if (i < int'(rr_if.mem_xfer_size) && rr_if.mem_address + 64'(i) < 64'(MemSize))
          mem[rr_if.mem_address[9:0] + 10'(i)] <= rr_if.mem_write_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    mem_rd = 64'd0;
    for (int i = 0; i < 8; i++) begin
      if (i < int'(rr_if.mem_xfer_size) && rr_if.mem_address + 64'(i) < 64'(MemSize))
        mem_rd[8*i +: 8] = mem[rr_if.mem_address[9:0] + 10'(i)];
    end
  end

  assign rr_if.mem_read_data = mem_rd;
  assign fp_if.mem_read_data = 64'd0;

  // Transaction-level reference: what memory should contain, what each request returns
  logic [7:0] ref_mem [MemSize];

  function automatic bit ref_err(input logic [63:0] a, input logic [3:0] s);
    if (s != 4'd1 && s != 4'd2 && s != 4'd4 && s != 4'd8) return 1'b1;
    if (a % 64'(s) != 64'd0) return 1'b1;
    if (a > 64'(MemSize) - 64'(s)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [63:0] ref_read(input logic [63:0] a, input logic [3:0] s);
    logic [63:0] d;
    d = 64'd0;
    for (int i = 0; i < int'(s); i++) d[8*i +: 8] = ref_mem[int'(a[9:0]) + i];
    return d;
  endfunction

  task automatic ref_write(input logic [63:0] a, input logic [63:0] wd, input logic [3:0] s);
    for (int i = 0; i < int'(s); i++) ref_mem[int'(a[9:0]) + i] = wd[8*i +: 8];
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic zero_inputs();
    rr_if.req_valid = 2'b00; rr_if.req_write = 2'b00;
    rr_if.req_addr0 = 64'd0; rr_if.req_addr1 = 64'd0;
    rr_if.req_wdata0 = 64'd0; rr_if.req_wdata1 = 64'd0;
    rr_if.req_size0 = 4'd0; rr_if.req_size1 = 4'd0;
    fp_if.req_valid = 2'b00; fp_if.req_write = 2'b00;
    fp_if.req_addr0 = 64'd0; fp_if.req_addr1 = 64'd0;
    fp_if.req_wdata0 = 64'd0; fp_if.req_wdata1 = 64'd0;
    fp_if.req_size0 = 4'd0; fp_if.req_size1 = 4'd0;
  endtask

  task automatic drive(input int port, input bit v, input bit wr, input logic [63:0] a,
                       input logic [63:0] wd, input logic [3:0] s);
    if (port == 0) begin
      rr_if.req_valid[0] = v; rr_if.req_write[0] = wr;
      rr_if.req_addr0 = a; rr_if.req_wdata0 = wd; rr_if.req_size0 = s;
    end else begin
      rr_if.req_valid[1] = v; rr_if.req_write[1] = wr;
      rr_if.req_addr1 = a; rr_if.req_wdata1 = wd; rr_if.req_size1 = s;
    end
  endtask

  // Issue one request on one port of dut_rr and check its whole life against the reference
  task automatic do_txn(input int port, input bit wr, input logic [63:0] a,
                        input logic [63:0] wd, input logic [3:0] s);
    bit          e;
    bit          acc;
    logic [63:0] exp_rd;
    logic [1:0]  onehot;
    e      = ref_err(a, s);
    exp_rd = (!wr && !e) ? ref_read(a, s) : 64'd0;
    onehot = (port == 0) ? 2'b01 : 2'b10;
    acc    = 1'b0;
    drive(port, 1'b1, wr, a, wd, s);
    for (int c = 0; c < 8; c++) begin
      #1;
      acc = rr_if.req_ready[port];
      @(posedge clk);
      if (acc) break;
      @(negedge clk);
    end
    check("accept", 64'(acc), 64'd1);
    @(negedge clk);
    drive(port, 1'b0, wr, a, wd, s);
    check("access_we", 64'(rr_if.mem_write_enable), 64'(wr && !e));
    check("access_re", 64'(rr_if.mem_read_enable), 64'(!wr && !e));
    check("access_no_resp", 64'(rr_if.resp_valid), 64'd0);
    if (wr && !e) ref_write(a, wd, s);
    @(negedge clk);
    check("resp_valid", 64'(rr_if.resp_valid), 64'(onehot));
    check("resp_err", 64'(rr_if.resp_err), 64'(e));
    check("resp_rdata", rr_if.resp_rdata, exp_rd);
  endtask

  initial begin
    int got;
    sz_tab[0] = 4'd1; sz_tab[1] = 4'd2; sz_tab[2] = 4'd4; sz_tab[3] = 4'd8;
    zero_inputs();
    for (int i = 0; i < int'(MemSize); i++) ref_mem[i] = 8'h00;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_ready", 64'(rr_if.req_ready), 64'd3);
    check("rst_resp_valid", 64'(rr_if.resp_valid), 64'd0);
    check("rst_xfer_size", 64'(rr_if.mem_xfer_size), 64'd8);
    check("rst_we", 64'(rr_if.mem_write_enable), 64'd0);
    check("rst_addr", rr_if.mem_address, 64'd0);
    mem_clear = 1'b0;
    reset_n   = 1'b1;
    @(negedge clk);

    // Both ports always valid: rr alternates starting at port 0, fp always picks port 0
    rr_if.req_valid = 2'b11; rr_if.req_size0 = 4'd8; rr_if.req_size1 = 4'd8;
    rr_if.req_addr1 = 64'h8;
    fp_if.req_valid = 2'b11; fp_if.req_size0 = 4'd8; fp_if.req_size1 = 4'd8;
    fp_if.req_addr1 = 64'h8;
    got = 0;
    for (int c = 0; c < 40 && got < 6; c++) begin
      @(negedge clk);
      if (rr_if.resp_valid != 2'b00) begin
        check("rr_grant", 64'(rr_if.resp_valid), (got % 2 == 1) ? 64'd2 : 64'd1);
        check("fp_grant", 64'(fp_if.resp_valid), 64'd1);
        got++;
      end
    end
    check("rr_resp_count", 64'(got), 64'd6);
    zero_inputs();
    repeat (3) @(negedge clk);

    // Write then read back; port 1 reads a halfword (byte 0x12 is the low byte)
    do_txn(0, 1'b1, 64'h10, 64'h1122_3344_5566_7788, 4'd8);
    do_txn(0, 1'b0, 64'h10, 64'd0, 4'd8);
    check("rd_literal_8", rr_if.resp_rdata, 64'h1122_3344_5566_7788);
    do_txn(1, 1'b0, 64'h12, 64'd0, 4'd2);
    check("rd_literal_2", rr_if.resp_rdata, 64'h0000_0000_0000_5566);

    // Rejected writes must leave memory untouched
    do_txn(0, 1'b1, 64'h13, 64'hFFFF_FFFF_FFFF_FFFF, 4'd4);
    do_txn(1, 1'b1, 64'h10, 64'hFFFF_FFFF_FFFF_FFFF, 4'd3);
    do_txn(0, 1'b1, 64'h3FC, 64'hFFFF_FFFF_FFFF_FFFF, 4'd8);
    do_txn(1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFFF, 4'd8);
    do_txn(0, 1'b0, 64'h10, 64'd0, 4'd8);

    // Top-of-memory boundaries
    do_txn(1, 1'b1, 64'h3F8, 64'h0102_0304_0506_0708, 4'd8);
    do_txn(0, 1'b0, 64'h3F8, 64'd0, 4'd8);
    do_txn(0, 1'b1, 64'h400, 64'h55, 4'd1);
    do_txn(1, 1'b0, 64'h3FF, 64'd0, 4'd1);
    do_txn(1, 1'b0, 64'h0, 64'd0, 4'd0);

    // Reset during the ACCESS cycle of a write aborts it
    do_txn(0, 1'b1, 64'h20, 64'hA5A5_5A5A_0F0F_F0F0, 4'd8);
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 64'h20, 64'hDEAD_BEEF_CAFE_F00D, 4'd8);
    #1;
    check("abort_ready", 64'(rr_if.req_ready), 64'd1);
    @(posedge clk);
    #1;
    drive(0, 1'b0, 1'b1, 64'h20, 64'hDEAD_BEEF_CAFE_F00D, 4'd8);
    check("abort_we_before", 64'(rr_if.mem_write_enable), 64'd1);
    reset_n = 1'b0;
    #1;
    check("abort_we_drop", 64'(rr_if.mem_write_enable), 64'd0);
    check("abort_addr", rr_if.mem_address, 64'd0);
    check("abort_size", 64'(rr_if.mem_xfer_size), 64'd8);
    @(posedge clk);
    @(negedge clk);
    check("abort_no_resp", 64'(rr_if.resp_valid), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("abort_no_resp_after", 64'(rr_if.resp_valid), 64'd0);
    drive(0, 1'b1, 1'b0, 64'h0, 64'd0, 4'd8);
    drive(1, 1'b1, 1'b0, 64'h8, 64'd0, 4'd8);
    #1;
    check("abort_tie_port0", 64'(rr_if.req_ready), 64'd1);
    drive(0, 1'b0, 1'b0, 64'h0, 64'd0, 4'd8);
    drive(1, 1'b0, 1'b0, 64'h8, 64'd0, 4'd8);
    do_txn(1, 1'b0, 64'h20, 64'd0, 4'd8);
    check("abort_old_value", rr_if.resp_rdata, 64'hA5A5_5A5A_0F0F_F0F0);

    // Random mix of ports, directions, sizes and addresses
    for (int k = 0; k < 40; k++) begin
      int unsigned r;
      logic [3:0]  s;
      logic [63:0] a;
      r = $urandom_range(0, 9);
      s = sz_tab[$urandom_range(0, 3)];
      a = 64'($urandom_range(0, MemSize - 1)) & ~(64'(s) - 64'd1);
      if (r == 0) s = 4'($urandom_range(0, 15));
      if (r == 1) a = {$urandom, $urandom};
      if (r == 2) a = 64'($urandom_range(0, MemSize - 1));
      do_txn(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, {$urandom, $urandom}, s);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
